fetch_sequencer: RTL

Instruction-fetch controller for the V-FRONT CPU. It sequences the PC counter by issuing one-cycle step and load strobes, and runs the req/ack handshake with instruction memory. It holds each fetched instruction in a one-entry buffer until decode takes it over a valid/ready handshake. It sits between the PC counter, instruction memory, decode, and the branch/jump resolution logic in execute.

---
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - PC-counter, instruction-memory and decode signals of the fetch sequencer
interface fetch_sequencer_if #(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 32
);
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_target;
  logic [PC_WIDTH-1:0]    pc;
  logic                   pc_step;
  logic                   pc_load;
  logic [PC_WIDTH-1:0]    pc_target;
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   fetch_fault;

  modport master (
    input  pc, redirect, redirect_target, imem_ack, imem_rdata, instr_ready,
    output pc_step, pc_load, pc_target, imem_req, imem_addr,
           instr_valid, instr, instr_pc, fetch_fault
  );

  modport slave (
    output pc, redirect, redirect_target, imem_ack, imem_rdata, instr_ready,
    input  pc_step, pc_load, pc_target, imem_req, imem_addr,
           instr_valid, instr, instr_pc, fetch_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller: PC strobes, imem req/ack, one-entry decode buffer
module fetch_sequencer #(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 32,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_DISCARD = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  logic [2:0]             state;
  logic [PC_WIDTH-1:0]    fetch_addr;
  logic [PC_WIDTH-1:0]    pending_addr;
  logic [PC_WIDTH-1:0]    instr_pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [7:0]             wait_cnt;
  logic                   fault;

  logic live;
  logic aligned;
  logic accept;
  logic misaligned;
  logic timeout;

  assign live       = (state != S_FAULT);
  assign aligned    = (bus.redirect_target[1:0] == 2'b00);
  assign accept     = live && bus.redirect && aligned;
  assign misaligned = live && bus.redirect && !aligned;
  assign timeout    = (wait_cnt == WAIT_LAST);

  // A redirect in the ack cycle wins, so the step is suppressed for any redirect.
  assign bus.pc_step     = (state == S_REQ) && bus.imem_ack && !bus.redirect;
  assign bus.pc_load     = rst && accept;
  assign bus.pc_target   = bus.redirect_target;
  assign bus.imem_req    = (state == S_REQ) || (state == S_DISCARD);
  assign bus.imem_addr   = fetch_addr;
  assign bus.instr_valid = (state == S_HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_fault = fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      fetch_addr   <= '0;
      pending_addr <= '0;
      instr_pc_q   <= '0;
      instr_q      <= '0;
      wait_cnt     <= '0;
      fault        <= 1'b0;
    end else if (misaligned) begin
      fault <= 1'b1;
      state <= S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          fetch_addr <= accept ? bus.redirect_target : bus.pc;
          wait_cnt   <= '0;
          state      <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_ack) begin
            wait_cnt <= '0;
            if (accept) begin
              fetch_addr <= bus.redirect_target;
            end else begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= fetch_addr;
              state      <= S_HOLD;
            end
          end else if (accept) begin
            // The old request stays on the bus; its data is dropped when it lands.
            pending_addr <= bus.redirect_target;
            wait_cnt     <= '0;
            state        <= S_DISCARD;
          end else if (timeout) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DISCARD: begin
          if (bus.imem_ack) begin
            fetch_addr <= accept ? bus.redirect_target : pending_addr;
            wait_cnt   <= '0;
            state      <= S_REQ;
          end else begin
            if (accept) pending_addr <= bus.redirect_target;
            if (timeout) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (accept) begin
            fetch_addr <= bus.redirect_target;
            wait_cnt   <= '0;
            state      <= S_REQ;
          end else if (bus.instr_ready) begin
            fetch_addr <= bus.pc;
            wait_cnt   <= '0;
            state      <= S_REQ;
          end
        end
        S_FAULT: ;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
